// File: rtl/wf_issue_scheduler.sv
// ============================================================================
// wf_issue_scheduler : round-robin wavefront issue scheduler with per-wavefront
//                      in-flight limiting and a valid/ack offer handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wf_issue_scheduler #(
    parameter int NUM_WF       = 40,
    parameter int WF_ID_W      = 6,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_WF-1:0]  wf_ready_i,
    output logic               issue_valid_o,
    output logic [WF_ID_W-1:0] issue_wf_id_o,
    input  logic               issue_ack_i,
    input  logic               retire_en_i,
    input  logic [WF_ID_W-1:0] retire_wf_id_i,
    input  logic               flush_en_i,
    input  logic [WF_ID_W-1:0] flush_wf_id_i,
    output logic [NUM_WF-1:0]  inflight_full_o,
    output logic               err_underflow_o
);

    localparam logic [0:0]         c_IDLE     = 1'b0;
    localparam logic [0:0]         c_OFFER    = 1'b1;
    localparam logic [CNT_W-1:0]   c_MAX      = CNT_W'(MAX_INFLIGHT);
    localparam logic [WF_ID_W:0]   c_NUM      = (WF_ID_W+1)'(NUM_WF);
    localparam logic [WF_ID_W-1:0] c_LAST_RST = WF_ID_W'(NUM_WF - 1);

    logic [0:0]                    state_q, state_d;
    logic [WF_ID_W-1:0]            wf_id_q, wf_id_d;
    logic [WF_ID_W-1:0]            last_q, last_d;
    logic                          err_q, err_d;
    logic [NUM_WF-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_WF-1:0]  w_eligible;
    logic [NUM_WF-1:0]  w_inc;
    logic [NUM_WF-1:0]  w_dec;
    logic [NUM_WF-1:0]  w_flush;
    logic [NUM_WF-1:0]  w_uflow;
    logic               w_found;
    logic [WF_ID_W-1:0] w_winner;
    logic [WF_ID_W:0]   w_sum;
    logic               w_issue;
    logic               w_flush_hit;

    for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_wf
        assign w_eligible[gi]      = wf_ready_i[gi] & (cnt_q[gi] != c_MAX);
        assign inflight_full_o[gi] = (cnt_q[gi] == c_MAX);
        assign w_inc[gi]           = w_issue & (wf_id_q == WF_ID_W'(gi));
        assign w_dec[gi]           = retire_en_i & (retire_wf_id_i == WF_ID_W'(gi));
        assign w_flush[gi]         = flush_en_i & (flush_wf_id_i == WF_ID_W'(gi));
    end

    // Search starts one past the last issued id and wraps modulo NUM_WF.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 1; k <= NUM_WF; k++) begin
            w_sum = {1'b0, last_q} + (WF_ID_W+1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (!w_found && w_eligible[w_sum[WF_ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[WF_ID_W-1:0];
            end
        end
    end

    assign w_flush_hit = flush_en_i & (flush_wf_id_i == wf_id_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            wf_id_q <= '0;
            last_q  <= c_LAST_RST;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wf_id_q <= wf_id_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // A flush of the offered id withdraws the offer and wins over an ack.
    always_comb begin
        state_d = state_q;
        wf_id_d = wf_id_q;
        w_issue = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_found) begin
                    state_d = c_OFFER;
                    wf_id_d = w_winner;
                end
            end
            c_OFFER: begin
                if (w_flush_hit) begin
                    state_d = c_IDLE;
                end else if (issue_ack_i) begin
                    state_d = c_IDLE;
                    w_issue = 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        issue_valid_o   = (state_q == c_OFFER);
        issue_wf_id_o   = wf_id_q;
        err_underflow_o = err_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        w_uflow = '0;
        last_d  = w_issue ? wf_id_q : last_q;
        for (int i = 0; i < NUM_WF; i++) begin
            if (w_flush[i]) begin
                cnt_d[i] = '0;
            end else if (w_inc[i] && w_dec[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (w_inc[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (w_dec[i]) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end else begin
                    w_uflow[i] = 1'b1;
                end
            end
        end
        err_d = err_q | (|w_uflow);
    end

endmodule

`default_nettype wire

// File: tb/tb_wf_issue_scheduler.sv
// ============================================================================
// tb_wf_issue_scheduler : scoreboard bench with a transaction-level reference
//                         model of the round-robin issue scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wf_issue_scheduler;

    localparam int N    = 40;
    localparam int IDW  = 6;
    localparam int MAXI = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   wf_ready;
    logic           issue_valid;
    logic [IDW-1:0] issue_wf_id;
    logic           ack;
    logic           ret_en;
    logic [IDW-1:0] ret_id;
    logic           fl_en;
    logic [IDW-1:0] fl_id;
    logic [N-1:0]   full;
    logic           err;

    wf_issue_scheduler #(
        .NUM_WF(N), .WF_ID_W(IDW), .MAX_INFLIGHT(MAXI), .CNT_W(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wf_ready_i     (wf_ready),
        .issue_valid_o  (issue_valid),
        .issue_wf_id_o  (issue_wf_id),
        .issue_ack_i    (ack),
        .retire_en_i    (ret_en),
        .retire_wf_id_i (ret_id),
        .flush_en_i     (fl_en),
        .flush_wf_id_i  (fl_id),
        .inflight_full_o(full),
        .err_underflow_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // Reference model state: reflects the DUT state after the next rising edge.
    int m_cnt[N];
    int m_last;
    bit m_valid;
    int m_id;
    bit m_err;
    bit last_issue;
    int last_issue_id;
    bit prev_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_last        = N - 1;
        m_valid       = 1'b0;
        m_id          = 0;
        m_err         = 1'b0;
        last_issue    = 1'b0;
        last_issue_id = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input bit [N-1:0] rdy, input bit a, input bit re,
                                       input int rid, input bit fe, input int fid);
        int issued = -1;
        int win    = -1;
        if (m_valid) begin
            if (fe && fid == m_id) m_valid = 1'b0;
            else if (a) begin
                issued  = m_id;
                m_valid = 1'b0;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int w;
                w = (m_last + k) % N;
                if (win < 0 && rdy[w] && m_cnt[w] < MAXI) win = w;
            end
            if (win >= 0) begin
                m_valid = 1'b1;
                m_id    = win;
                exp_q.push_back(win);
            end
        end
        if (re && rid < N && rid != issued && !(fe && fid == rid)) begin
            if (m_cnt[rid] > 0) m_cnt[rid]--;
            else m_err = 1'b1;
        end
        if (issued >= 0) begin
            if (!(re && rid == issued)) m_cnt[issued]++;
            m_last = issued;
        end
        if (fe && fid < N) m_cnt[fid] = 0;
        last_issue    = (issued >= 0);
        last_issue_id = (issued >= 0) ? issued : 0;
    endfunction

    function automatic logic [N-1:0] model_full();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = (m_cnt[i] == MAXI);
        return f;
    endfunction

    task automatic step(input bit [N-1:0] rdy, input bit a, input bit re, input int rid,
                        input bit fe, input int fid);
        @(negedge clk);
        wf_ready = rdy;
        ack      = a;
        ret_en   = re;
        ret_id   = IDW'(rid);
        fl_en    = fe;
        fl_id    = IDW'(fid);
        model_step(rdy, a, re, rid, fe, fid);
    endtask

    task automatic idle_inputs();
        wf_ready = '0;
        ack      = 1'b0;
        ret_en   = 1'b0;
        ret_id   = '0;
        fl_en    = 1'b0;
        fl_id    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic async_reset_check();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, issue_valid}, 64'd0);
        chk("async_rst_id", {58'd0, issue_wf_id}, 64'd0);
        chk("async_rst_full", {24'd0, full}, 64'd0);
        chk("async_rst_err", {63'd0, err}, 64'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each new offer.
    always @(posedge clk) begin
        #1;
        chk("valid", {63'd0, issue_valid}, {63'd0, m_valid});
        if (issue_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                chk("offer_unexpected", 64'd1, 64'd0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("offer_id", {58'd0, issue_wf_id}, 64'(e));
            end
        end else if (issue_valid) begin
            chk("held_id", {58'd0, issue_wf_id}, 64'(m_id));
        end
        chk("inflight_full", {24'd0, full}, {24'd0, model_full()});
        chk("err_underflow", {63'd0, err}, {63'd0, m_err});
        prev_v = issue_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [N-1:0] b5, b7, b3, b12, b39, b2;
        bit done;
        prev_v = 1'b0;
        rst_n  = 1'b0;
        idle_inputs();
        model_reset();
        b2 = '0; b2[2] = 1'b1;
        b3 = '0; b3[3] = 1'b1;
        b5 = '0; b5[5] = 1'b1;
        b7 = '0; b7[7] = 1'b1;
        b12 = '0; b12[12] = 1'b1;
        b39 = '0; b39[39] = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid", {63'd0, issue_valid}, 64'd0);
        chk("reset_full", {24'd0, full}, 64'd0);
        rst_n = 1'b1;

        // All ready, always ack, retire echoes each issue.
        for (int c = 0; c < 86; c++) step('1, 1'b1, last_issue, last_issue_id, 1'b0, 0);

        // Single wavefront hits its in-flight limit.
        do_reset();
        for (int c = 0; c < 12; c++) step(b5, 1'b1, 1'b0, 0, 1'b0, 0);
        @(posedge clk); #1;
        chk("wf5_full", {63'd0, full[5]}, 64'd1);
        chk("wf5_blocked", {63'd0, issue_valid}, 64'd0);
        step(b5, 1'b1, 1'b1, 5, 1'b0, 0);
        for (int c = 0; c < 8; c++) step(b5, 1'b1, 1'b0, 0, 1'b0, 0);
        @(posedge clk); #1;
        chk("wf5_full_again", {63'd0, full[5]}, 64'd1);

        // Wrap from id 39 to id 2.
        do_reset();
        for (int c = 0; c < 3; c++) step(b39, 1'b1, 1'b0, 0, 1'b0, 0);
        for (int c = 0; c < 6; c++) step(b2 | b39, 1'b1, 1'b0, 0, 1'b0, 0);

        // Offer held while the offered ready bit toggles.
        do_reset();
        step(b12, 1'b0, 1'b0, 0, 1'b0, 0);
        for (int c = 0; c < 5; c++) begin
            step(($urandom % 2) ? b12 : '0, 1'b0, 1'b0, 0, 1'b0, 0);
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, issue_valid}, 64'd1);
            chk("hold_id", {58'd0, issue_wf_id}, 64'd12);
        end
        step('0, 1'b1, 1'b0, 0, 1'b0, 0);
        for (int c = 0; c < 8; c++) step(b12, 1'b1, 1'b0, 0, 1'b0, 0);

        // Flush of the offered id with a same-cycle ack.
        do_reset();
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (m_valid && m_id == 7 && m_cnt[7] == 2) begin
                step(b7, 1'b1, 1'b0, 0, 1'b1, 7);
                done = 1'b1;
            end else begin
                step(b7, 1'b1, 1'b0, 0, 1'b0, 0);
            end
        end
        chk("flush_setup_reached", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        chk("flush_drops_valid", {63'd0, issue_valid}, 64'd0);
        for (int c = 0; c < 8; c++) step(b7 | b3, 1'b1, 1'b0, 0, 1'b0, 0);

        // Underflow, then ack+retire on the same id.
        do_reset();
        step('0, 1'b0, 1'b1, 10, 1'b0, 0);
        for (int c = 0; c < 2; c++) step('0, 1'b0, 1'b0, 0, 1'b0, 0);
        chk("underflow_set", {63'd0, err}, 64'd1);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (m_valid && m_id == 3 && m_cnt[3] == 1) begin
                step(b3, 1'b1, 1'b1, 3, 1'b0, 0);
                done = 1'b1;
            end else begin
                step(b3, 1'b1, 1'b0, 0, 1'b0, 0);
            end
        end
        chk("ackret_setup_reached", {63'd0, done}, 64'd1);
        for (int c = 0; c < 10; c++) step(b3, 1'b1, 1'b0, 0, 1'b0, 0);
        chk("underflow_sticky", {63'd0, err}, 64'd1);

        // Randomized traffic, including out-of-range retire/flush ids.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit [N-1:0] r;
            int fid;
            r   = {$urandom, $urandom};
            fid = ($urandom % 2) ? m_id : int'($urandom % 45);
            step(r, ($urandom % 3) != 0, ($urandom % 3) == 0, int'($urandom % 45),
                 ($urandom % 12) == 0, fid);
        end

        // Asynchronous reset while an offer is pending.
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step('1, 1'b0, 1'b0, 0, 1'b0, 0);
            if (m_valid) done = 1'b1;
        end
        chk("offer_before_reset", {63'd0, done}, 64'd1);
        async_reset_check();
        for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b0, 0, 1'b0, 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
